signed_seq_divider: RTL and testbench
=====================================

// Module: signed_seq_divider
// PURPOSE
//   Sequential two's-complement integer divider for the ALU32 datapath; the inverse of the signed array multiplier.
//   Takes an N-bit signed dividend and divisor on init. Uses a restoring shift-subtract loop on magnitudes,
//   producing one quotient bit per clock. Returns the quotient truncated toward zero, plus a remainder carrying
//   the dividend's sign. Sits beside the multiplier in the ALU and is started and polled the same way.
// PARAMETERS
//   N  16  operand, quotient and remainder width in bits; must be even and in the range 4..32
// PORTS
//   clock        in   1  single clock; all state updates on posedge
//   resetn       in   1  synchronous, active-low reset
//   init         in   1  start request; sampled only in IDLE
//   dividend     in   N  signed dividend; sampled on the accepting edge
//   divisor      in   N  signed divisor; sampled on the accepting edge
//   quotient     out  N  signed quotient; held until the next result
//   remainder    out  N  signed remainder; held until the next result
//   busy         out  1  high from the accepting edge until the result edge
//   done         out  1  one-cycle pulse, asserted with valid quotient/remainder
//   div_by_zero  out  1  valid with done; divisor was 0
//   overflow     out  1  valid with done; operands were -2^(N-1) / -1
// BEHAVIOUR
//   Reset (resetn=0 at a posedge):
//     - state=IDLE; quotient, remainder, busy, done, div_by_zero and overflow all go to 0.
//     - Reset wins over every other input, including in the middle of an operation.
//       The partial result is discarded and no done is issued.
//   States: IDLE -> CALC -> FIX -> IDLE.
//   IDLE:
//     - On an edge with init=1 (edge 0), latch |dividend| into a 2N-bit {rem,quo} shift register.
//       Latch |divisor| as N bits unsigned; |-2^(N-1)| = 2^(N-1) fits. Latch both sign bits.
//     - Clear count (width clog2(N+1)) and set busy=1.
//     - If divisor==0, go to FIX with the dbz flag set. Otherwise go to CALC.
//   CALC (edges 1..N):
//     - Shift {rem,quo} left by 1. Form trial = rem_shifted - |divisor| at N+1 bits.
//     - If trial >= 0: rem <= trial[N-1:0] and quo[0] <= 1. Otherwise restore, with quo[0] <= 0.
//     - count++. After the N-th step, go to FIX.
//   FIX (edge N+1, or edge 1 on divide by zero):
//     - quotient  <= (sign_a ^ sign_b) ? -quo : quo, modulo 2^N.
//     - remainder <= sign_a ? -rem : rem.
//     - Set done=1 for this one cycle and busy=0, then go to IDLE.
//   Latency: done is high in the cycle after edge N+1 (N+2 edges counted from the accepting edge).
//     Divide by zero completes in 2 edges.
//   Divide by zero: quotient = all-ones (-1), remainder = the dividend unchanged, div_by_zero=1.
//   Overflow: -2^(N-1) / -1 gives quotient = -2^(N-1) (wraps), remainder = 0, overflow=1.
//   init while busy: ignored, with no queueing. init held high through done re-arms on the first edge back in IDLE.
//   Outputs (quotient, remainder, div_by_zero, overflow) change only at the FIX edge or at reset.
//   Outside FIX, done=0.
//   Inputs dividend and divisor may change freely after the accepting edge.
// STRUCTURE
//   Shared package (alu32_pkg): LOG2/clog2 macro, state encodings (DIV_IDLE, DIV_CALC, DIV_FIX),
//   and a ZERO/ONES-of-width helper.
//   Sub-module div_step #(N): combinational single restoring step.
//     Inputs: rem, quo, divisor magnitude. Outputs: next rem, next quo.
//   Top: FSM, counter, sign/abs logic and output registers. Estimated 150-250 lines.
// TESTING
//   The bench checks done timing against the cycle numbers given above for every case.
//   1. N=16, 100 / 7 -> quotient=14, remainder=2, done exactly 18 edges after the accepting edge, flags 0.
//   2. -100/7 -> q=-14 (0xFFF2), r=-2 (0xFFFE). 100/-7 -> q=-14, r=2. -100/-7 -> q=14, r=-2.
//   3. -32768 / -1 -> q=0x8000, r=0, overflow=1. Also -32768 / 1 -> q=0x8000, r=0, overflow=0.
//   4. 5 / 0 -> q=0xFFFF, r=5, div_by_zero=1, done 2 edges after the accepting edge.
//   5. Start 1000/3, assert resetn=0 at edge 8 -> all outputs 0, no done. Then 9/3 -> q=3, r=0.
//   6. Start 7/2, pulse init with 50/5 at edge 4 -> ignored. Result q=3, r=1, then q/r held stable for 10 idle cycles.

Source files
------------

// File: rtl/signed_seq_divider_pkg.sv
// Shared definitions for the sequential signed divider: FSM encoding and width helpers.
package signed_seq_divider_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2
    } div_state_t;

    localparam int unsigned DIV_MIN_W = 4;
    localparam int unsigned DIV_MAX_W = 32;

    // Number of bits needed to hold values 0..v-1.
    function automatic int unsigned log2c(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    function automatic logic [63:0] ones_of(input int unsigned w);
        return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] zeros_of(input int unsigned w);
        return (w >= 64) ? 64'd0 : (64'd0 & ones_of(w));
    endfunction

endpackage

// File: rtl/signed_seq_divider_div_step.sv
// One restoring shift-subtract step on unsigned magnitudes; purely combinational.
module div_step
    import signed_seq_divider_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0] rem_i,
    input  logic [N-1:0] quo_i,
    input  logic [N-1:0] dvs_i,
    output logic [N-1:0] rem_o,
    output logic [N-1:0] quo_o
);

    logic [N:0] rem_sh;
    logic [N:0] trial;

    // rem stays below the divisor, so the shifted value fits in N+1 bits
    assign rem_sh = {rem_i, quo_i[N-1]};
    assign trial  = rem_sh - {1'b0, dvs_i};

    always_comb begin
        rem_o = rem_sh[N-1:0];
        quo_o = {quo_i[N-2:0], 1'b0};
        if (!trial[N]) begin
            rem_o = trial[N-1:0];
            quo_o = {quo_i[N-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/signed_seq_divider.sv
// Sequential two's-complement divider: quotient truncates toward zero, remainder takes the dividend's sign.
module signed_seq_divider
    import signed_seq_divider_pkg::*;
#(
    parameter int N = 16
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                init,
    input  logic signed [N-1:0] dividend,
    input  logic signed [N-1:0] divisor,
    output logic signed [N-1:0] quotient,
    output logic signed [N-1:0] remainder,
    output logic                busy,
    output logic                done,
    output logic                div_by_zero,
    output logic                overflow
);

    localparam int unsigned   CW     = log2c(N + 1);
    localparam logic [CW-1:0] LAST   = CW'(N - 1);
    localparam logic [63:0]   ONES64 = ones_of(N);
    localparam logic [N-1:0]  ONES   = ONES64[N-1:0];
    localparam logic [N-1:0]  MINV   = {1'b1, {(N-1){1'b0}}};

    div_state_t    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic          sa_q, sa_d, sb_q, sb_d, dbz_q, dbz_d, ovf_q, ovf_d;
    logic [N-1:0]  quot_q, quot_d, remo_q, remo_d;
    logic          busy_q, busy_d, done_q, done_d, dbzo_q, dbzo_d, ovfo_q, ovfo_d;
    logic [N-1:0]  a_mag, b_mag, step_rem, step_quo, fix_rem;

    assign a_mag   = dividend[N-1] ? $unsigned(-dividend) : $unsigned(dividend);
    assign b_mag   = divisor[N-1]  ? $unsigned(-divisor)  : $unsigned(divisor);
    // On divide by zero the untouched |dividend| is still in the quo field
    assign fix_rem = dbz_q ? quo_q : rem_q;

    div_step #(.N(N)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbzo_d  = dbzo_q;
        ovfo_d  = ovfo_q;
        case (state_q)
            DIV_IDLE: begin
                if (init) begin
                    rem_d   = '0;
                    quo_d   = a_mag;
                    dvs_d   = b_mag;
                    sa_d    = dividend[N-1];
                    sb_d    = divisor[N-1];
                    dbz_d   = (divisor == '0);
                    ovf_d   = ($unsigned(dividend) == MINV) && ($unsigned(divisor) == ONES);
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = (divisor == '0) ? DIV_FIX : DIV_CALC;
                end
            end
            DIV_CALC: begin
                rem_d   = step_rem;
                quo_d   = step_quo;
                count_d = count_q + 1'b1;
                if (count_q == LAST) state_d = DIV_FIX;
            end
            DIV_FIX: begin
                quot_d  = dbz_q ? ONES : ((sa_q ^ sb_q) ? -quo_q : quo_q);
                remo_d  = sa_q ? -fix_rem : fix_rem;
                dbzo_d  = dbz_q;
                ovfo_d  = ovf_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= DIV_IDLE;
            count_q <= '0;
            quot_q  <= '0;
            remo_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbzo_q  <= 1'b0;
            ovfo_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbzo_q  <= dbzo_d;
            ovfo_q  <= ovfo_d;
        end
    end

    // Working registers are always loaded at acceptance, so they need no reset
    always_ff @(posedge clock) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        dvs_q <= dvs_d;
        sa_q  <= sa_d;
        sb_q  <= sb_d;
        dbz_q <= dbz_d;
        ovf_q <= ovf_d;
    end

    assign quotient    = quot_q;
    assign remainder   = remo_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbzo_q;
    assign overflow    = ovfo_q;

endmodule

// File: tb/tb_signed_seq_divider.sv
// Scoreboard bench for signed_seq_divider (N=16) with directed, hand-computed vectors.
module tb_signed_seq_divider;

    localparam int N = 16;

    logic          clock = 1'b0;
    logic          resetn;
    logic          init;
    logic [N-1:0]  dividend;
    logic [N-1:0]  divisor;
    logic [N-1:0]  quotient;
    logic [N-1:0]  remainder;
    logic          busy, done, div_by_zero, overflow;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        logic         ov;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int total_cnt = 0;
    int pass_cnt  = 0;

    signed_seq_divider #(.N(N)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .init        (init),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Latency is the index of the edge (accepting edge = 0) after which done is first seen high:
    // N+1 for a normal divide, 1 for divide by zero.
    initial begin : monitor
        logic bprev;
        int   cnt;
        exp_t e;
        bprev = 1'b0;
        cnt   = 0;
        forever begin
            @(posedge clock);
            #1;
            if (busy === 1'b1 && bprev !== 1'b1) cnt = 0;
            else cnt++;
            bprev = busy;
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_done: got done=1 expected no done at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    chk("quotient",    32'(quotient),    32'(e.q));
                    chk("remainder",   32'(remainder),   32'(e.r));
                    chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
                    chk("overflow",    32'(overflow),    32'(e.ov));
                    chk("latency",     32'(cnt),         32'(e.lat));
                end
            end
        end
    end

    task automatic wait_done();
        int k;
        k = 0;
        while (done !== 1'b1 && k < 60) begin
            @(posedge clock);
            #1;
            k++;
        end
        if (done !== 1'b1) begin
            total_cnt++;
            $display("FAIL done_timeout: got no done expected done within 60 cycles at %0t", $time);
        end
    endtask

    task automatic push(input logic [N-1:0] q, input logic [N-1:0] r, input logic dz,
                        input logic ov, input int lat);
        exp_t e;
        e.q = q; e.r = r; e.dz = dz; e.ov = ov; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clock);
        dividend = a;
        divisor  = b;
        init     = 1'b1;
        @(posedge clock);
        #2;
        init     = 1'b0;
        dividend = 16'h5A5A;
        divisor  = 16'hA5A5;
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] q,
                          input logic [N-1:0] r, input logic dz, input logic ov, input int lat);
        push(q, r, dz, ov, lat);
        issue(a, b);
        wait_done();
    endtask

    initial begin : stim
        int dones;
        resetn   = 1'b0;
        init     = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_quotient",  32'(quotient),    32'h0);
        chk("rst_remainder", 32'(remainder),   32'h0);
        chk("rst_busy",      32'(busy),        32'h0);
        chk("rst_done",      32'(done),        32'h0);
        chk("rst_dbz",       32'(div_by_zero), 32'h0);
        chk("rst_ovf",       32'(overflow),    32'h0);
        @(negedge clock);
        resetn = 1'b1;

        run_op(16'd100,     16'd7,      16'd14,    16'd2,     1'b0, 1'b0, N + 1);
        run_op(-16'sd100,   16'd7,      16'hFFF2,  16'hFFFE,  1'b0, 1'b0, N + 1);
        run_op(16'd100,     -16'sd7,    16'hFFF2,  16'h0002,  1'b0, 1'b0, N + 1);
        run_op(-16'sd100,   -16'sd7,    16'h000E,  16'hFFFE,  1'b0, 1'b0, N + 1);
        run_op(16'h8000,    16'hFFFF,   16'h8000,  16'h0000,  1'b0, 1'b1, N + 1);
        run_op(16'h8000,    16'h0001,   16'h8000,  16'h0000,  1'b0, 1'b0, N + 1);
        run_op(16'h7FFF,    16'h8000,   16'h0000,  16'h7FFF,  1'b0, 1'b0, N + 1);
        run_op(16'd5,       16'd0,      16'hFFFF,  16'h0005,  1'b1, 1'b0, 1);
        run_op(-16'sd5,     16'd0,      16'hFFFF,  16'hFFFB,  1'b1, 1'b0, 1);

        // Reset in the middle of 1000/3: result discarded, outputs cleared, no done
        issue(16'd1000, 16'd3);
        repeat (7) @(posedge clock);
        @(negedge clock);
        resetn = 1'b0;
        @(posedge clock);
        #1;
        chk("midrst_quotient",  32'(quotient),    32'h0);
        chk("midrst_remainder", 32'(remainder),   32'h0);
        chk("midrst_busy",      32'(busy),        32'h0);
        chk("midrst_dbz",       32'(div_by_zero), 32'h0);
        @(negedge clock);
        resetn = 1'b1;
        dones = 0;
        repeat (N + 4) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) dones++;
        end
        chk("midrst_no_done", 32'(dones), 32'h0);
        run_op(16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 1'b0, N + 1);

        // init pulsed with 50/5 while 7/2 is running must be ignored
        push(16'd3, 16'd1, 1'b0, 1'b0, N + 1);
        issue(16'd7, 16'd2);
        repeat (3) @(posedge clock);
        @(negedge clock);
        dividend = 16'd50;
        divisor  = 16'd5;
        init     = 1'b1;
        @(posedge clock);
        #2;
        init = 1'b0;
        wait_done();
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            chk("hold_quotient",  32'(quotient),  32'd3);
            chk("hold_remainder", 32'(remainder), 32'd1);
            chk("hold_done",      32'(done),      32'h0);
        end

        repeat (3) @(posedge clock);
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
